// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM state encoding and bit-period helper.
// Combinational constants only; no timing or flow-control behaviour of its own.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic int cycles_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with full/empty flags; a pushed word reaches pop_dat_o one cycle later.
// Pushes while full and pops while empty are ignored; output reads 0 while empty.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (cnt_q == (AW + 1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_cfg.sv
// Parametrised UART with TX/RX FIFOs; serial_out lags the TX FSM by one register, RX words land one cycle after the stop midpoint.
// data_in_ready drops when the TX FIFO is full; a good RX word arriving at a full RX FIFO is dropped with an overrun pulse.
module uart_cfg #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    input  logic                 serial_in,
    output logic                 serial_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);
    import uart_pkg::*;

    localparam int             BIT_CYC  = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int             CW       = $clog2(BIT_CYC + 1);
    localparam logic [CW-1:0]  LAST_CYC = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0]  MID_CYC  = CW'(BIT_CYC / 2);
    localparam logic           ODD      = 1'(PARITY == PAR_ODD);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BIT_CYC < 2) begin : g_bad_param
        $error("uart_cfg: illegal parameter value");
    end

    logic                 tx_rdy_q, tx_full, tx_empty, tx_pop, tx_line, serial_q;
    logic [DATA_BITS-1:0] tx_head, tx_sh_q, tx_sh_d;
    uart_state_e          tx_st_q, tx_st_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_idx_q, tx_idx_d;
    logic                 tx_par_q, tx_par_d;

    assign data_in_ready = tx_rdy_q && !tx_full;
    assign serial_out    = serial_q;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n),
        .push_i(data_in_valid && data_in_ready), .push_dat_i(data_in),
        .pop_i(tx_pop), .pop_dat_o(tx_head),
        .full_o(tx_full), .empty_o(tx_empty)
    );

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q + 1'b1;
        tx_idx_d = tx_idx_q;
        tx_sh_d  = tx_sh_q;
        tx_par_d = tx_par_q;
        tx_pop   = 1'b0;
        tx_line  = 1'b1;
        case (tx_st_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                tx_pop   = !tx_empty;
            end
            ST_START: begin
                tx_line = 1'b0;
                if (tx_cnt_q == LAST_CYC) begin
                    tx_cnt_d = '0;
                    tx_idx_d = '0;
                    tx_st_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_line = tx_sh_q[0];
                if (tx_cnt_q == LAST_CYC) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_idx_d = tx_idx_q + 1'b1;
                    if (tx_idx_q == 4'(DATA_BITS - 1)) begin
                        tx_idx_d = '0;
                        tx_st_d  = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                tx_line = tx_par_q;
                if (tx_cnt_q == LAST_CYC) begin
                    tx_cnt_d = '0;
                    tx_st_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == LAST_CYC) begin
                    tx_cnt_d = '0;
                    tx_idx_d = tx_idx_q + 1'b1;
                    if (tx_idx_q == 4'(STOP_BITS - 1)) begin
                        tx_st_d = ST_IDLE;
                        tx_pop  = !tx_empty;
                    end
                end
            end
            default: tx_st_d = ST_IDLE;
        endcase
        // Loading straight from STOP keeps back-to-back frames gapless.
        if (tx_pop) begin
            tx_st_d  = ST_START;
            tx_cnt_d = '0;
            tx_sh_d  = tx_head;
            tx_par_d = ^tx_head ^ ODD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_rdy_q <= 1'b0;
            tx_st_q  <= ST_IDLE;
            tx_cnt_q <= '0;
            tx_idx_q <= '0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
            serial_q <= 1'b1;
        end else begin
            tx_rdy_q <= 1'b1;
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_idx_q <= tx_idx_d;
            tx_sh_q  <= tx_sh_d;
            tx_par_q <= tx_par_d;
            serial_q <= tx_line;
        end
    end

    logic                 rx_meta_q, rx_sync_q, rx_prev_q, rx_full, rx_empty;
    uart_state_e          rx_st_q, rx_st_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_pb_q, rx_pb_d, rx_brk_q, rx_brk_d;
    logic                 good_q, good_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 rx_par_exp;

    assign rx_par_exp     = ^rx_sh_q ^ ODD;
    assign data_out_valid = !rx_empty;
    assign parity_err     = perr_q;
    assign frame_err      = ferr_q;
    assign overrun        = good_q && rx_full;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n),
        .push_i(good_q && !rx_full), .push_dat_i(rx_sh_q),
        .pop_i(data_out_ready), .pop_dat_o(data_out),
        .full_o(rx_full), .empty_o(rx_empty)
    );

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q + 1'b1;
        rx_idx_d = rx_idx_q;
        rx_sh_d  = rx_sh_q;
        rx_pb_d  = rx_pb_q;
        rx_brk_d = rx_brk_q;
        good_d   = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        case (rx_st_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_st_d = ST_START;
            end
            ST_START: begin
                if (rx_cnt_q == MID_CYC) begin
                    rx_cnt_d = '0;
                    rx_idx_d = '0;
                    rx_st_d  = rx_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == LAST_CYC) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
                    rx_idx_d = rx_idx_q + 1'b1;
                    if (rx_idx_q == 4'(DATA_BITS - 1))
                        rx_st_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (rx_cnt_q == LAST_CYC) begin
                    rx_cnt_d = '0;
                    rx_pb_d  = rx_sync_q;
                    rx_st_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                // After a framing error, hold here until the line is back high.
                if (rx_brk_q) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_brk_d = 1'b0;
                        rx_st_d  = ST_IDLE;
                    end
                end else if (rx_cnt_q == LAST_CYC) begin
                    rx_cnt_d = '0;
                    if (!rx_sync_q) begin
                        ferr_d   = 1'b1;
                        rx_brk_d = 1'b1;
                    end else begin
                        rx_st_d = ST_IDLE;
                        if (PARITY != PAR_NONE && rx_pb_q != rx_par_exp) perr_d = 1'b1;
                        else                                             good_d = 1'b1;
                    end
                end
            end
            default: rx_st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= ST_IDLE;
            rx_cnt_q  <= '0;
            rx_idx_q  <= '0;
            rx_sh_q   <= '0;
            rx_pb_q   <= 1'b0;
            rx_brk_q  <= 1'b0;
            good_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= serial_in;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_idx_q  <= rx_idx_d;
            rx_sh_q   <= rx_sh_d;
            rx_pb_q   <= rx_pb_d;
            rx_brk_q  <= rx_brk_d;
            good_q    <= good_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: three instances (8N1 depth 4, 7E2 loopback, 8O1) driven with random words
// and checked against a frame/queue model built from the line format rules.
module tb_uart_cfg;

    localparam int CF = 1_000_000;
    localparam int BR = 100_000;
    localparam int BC = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic [7:0] a_din, a_dout;
    logic       a_div, a_rdy, a_dov, a_dor, a_sin, a_sout, a_perr, a_ferr, a_ovr, a_loop, a_inj;
    logic [6:0] b_din, b_dout;
    logic       b_div, b_rdy, b_dov, b_dor, b_sout, b_perr, b_ferr, b_ovr;
    logic [7:0] c_din, c_dout;
    logic       c_div, c_rdy, c_dov, c_dor, c_inj, c_sout, c_perr, c_ferr, c_ovr;

    assign a_sin = a_loop ? a_sout : a_inj;

    uart_cfg #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset_n(reset_n), .data_in(a_din), .data_in_valid(a_div), .data_in_ready(a_rdy),
        .data_out(a_dout), .data_out_valid(a_dov), .data_out_ready(a_dor), .serial_in(a_sin),
        .serial_out(a_sout), .parity_err(a_perr), .frame_err(a_ferr), .overrun(a_ovr));

    uart_cfg #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .reset_n(reset_n), .data_in(b_din), .data_in_valid(b_div), .data_in_ready(b_rdy),
        .data_out(b_dout), .data_out_valid(b_dov), .data_out_ready(b_dor), .serial_in(b_sout),
        .serial_out(b_sout), .parity_err(b_perr), .frame_err(b_ferr), .overrun(b_ovr));

    uart_cfg #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_c (
        .clk(clk), .reset_n(reset_n), .data_in(c_din), .data_in_valid(c_div), .data_in_ready(c_rdy),
        .data_out(c_dout), .data_out_valid(c_dov), .data_out_ready(c_dor), .serial_in(c_inj),
        .serial_out(c_sout), .parity_err(c_perr), .frame_err(c_ferr), .overrun(c_ovr));

    int a_pe_n = 0, a_fe_n = 0, a_ov_n = 0;
    int b_pe_n = 0, b_fe_n = 0, b_ov_n = 0;
    int c_pe_n = 0, c_fe_n = 0, c_ov_n = 0;
    always @(negedge clk) begin
        a_pe_n += int'(a_perr); a_fe_n += int'(a_ferr); a_ov_n += int'(a_ovr);
        b_pe_n += int'(b_perr); b_fe_n += int'(b_ferr); b_ov_n += int'(b_ovr);
        c_pe_n += int'(c_perr); c_fe_n += int'(c_ferr); c_ov_n += int'(c_ovr);
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Line image of one frame, bit 0 first on the wire.
    function automatic logic [15:0] frame_bits(input logic [8:0] w, input int db, input int par, input int sb);
        logic [15:0] f;
        int          n;
        logic        p;
        f = '0;
        n = 1;
        p = 1'b0;
        for (int i = 0; i < db; i++) begin
            f[n] = w[i];
            p    = p ^ w[i];
            n++;
        end
        if (par != 0) begin
            f[n] = (par == 2) ? ~p : p;
            n++;
        end
        for (int s = 0; s < sb; s++) begin
            f[n] = 1'b1;
            n++;
        end
        return f;
    endfunction

    int          mon_sel = 0;
    logic        mon_line;
    logic [15:0] exp_fr [8];
    assign mon_line = (mon_sel == 0) ? a_sout : b_sout;

    task automatic capture(input int nfr, input int fbits, input string tag);
        int          t;
        logic [15:0] first, last;
        t = 0;
        while (mon_line !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            check({tag, "_start_timeout"}, 0, 1);
        end else begin
            for (int f = 0; f < nfr; f++) begin
                first = '0;
                last  = '0;
                for (int b = 0; b < fbits; b++) begin
                    for (int k = 0; k < BC; k++) begin
                        if (k == 0)      first[b] = mon_line;
                        if (k == BC - 1) last[b]  = mon_line;
                        @(negedge clk);
                    end
                end
                check({tag, "_early"}, 32'(first), 32'(exp_fr[f]));
                check({tag, "_late"},  32'(last),  32'(exp_fr[f]));
            end
        end
    endtask

    task automatic wr(input int sel, input logic [8:0] w);
        int t;
        t = 0;
        while (((sel == 0) ? a_rdy : b_rdy) !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("wr_ready_timeout", 0, 1);
        if (sel == 0) begin a_din = w[7:0]; a_div = 1'b1; end
        else          begin b_din = w[6:0]; b_div = 1'b1; end
        @(negedge clk);
        a_div = 1'b0;
        b_div = 1'b0;
    endtask

    task automatic rd(input int sel, input string tag, input logic [8:0] exp);
        int         t;
        logic       v;
        logic [8:0] d;
        t = 0;
        v = 1'b0;
        while (t < 3000) begin
            v = (sel == 0) ? a_dov : (sel == 1) ? b_dov : c_dov;
            if (v) break;
            @(negedge clk);
            t++;
        end
        if (!v) begin
            check({tag, "_valid_timeout"}, 0, 1);
        end else begin
            d = (sel == 0) ? {1'b0, a_dout} : (sel == 1) ? {2'b0, b_dout} : {1'b0, c_dout};
            check(tag, 32'(d), 32'(exp));
            if (sel == 0) a_dor = 1'b1; else if (sel == 1) b_dor = 1'b1; else c_dor = 1'b1;
            @(negedge clk);
            a_dor = 1'b0; b_dor = 1'b0; c_dor = 1'b0;
        end
    endtask

    task automatic inject(input int sel, input logic [15:0] bits, input int n);
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < BC; k++) begin
                if (sel == 0) a_inj = bits[b]; else c_inj = bits[b];
                @(negedge clk);
            end
        end
        if (sel == 0) a_inj = 1'b1; else c_inj = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    logic [8:0]  ws [8];
    logic [8:0]  w;
    logic [15:0] bits;
    logic [8:0]  rxq [$];
    int          base, n_ovr;

    initial begin
        reset_n = 1'b0;
        a_din = '0; a_div = 1'b0; a_dor = 1'b0; a_loop = 1'b0; a_inj = 1'b1;
        b_din = '0; b_div = 1'b0; b_dor = 1'b0;
        c_din = '0; c_div = 1'b0; c_dor = 1'b0; c_inj = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sout", 32'(a_sout), 1);
        check("rst_rdy", 32'({a_rdy, b_rdy, c_rdy}), 0);
        check("rst_dov", 32'({a_dov, b_dov, c_dov}), 0);
        check("rst_dout", 32'(a_dout), 0);
        check("rst_err", 32'({a_perr, a_ferr, a_ovr}), 0);
        check("rst_sout_c", 32'(c_sout), 1);
        reset_n = 1'b1;
        @(negedge clk);
        check("rdy_first_cycle", 32'({a_rdy, b_rdy}), 32'b11);

        // 8N1 waveform of 0xA5, then three random back-to-back frames
        exp_fr[0] = frame_bits(9'h0A5, 8, 0, 1);
        fork
            capture(1, 10, "a5_frame");
            wr(0, 9'h0A5);
        join
        check("a5_idle_after", 32'(a_sout), 1);
        for (int i = 0; i < 3; i++) begin
            ws[i]     = 9'($urandom_range(0, 255));
            exp_fr[i] = frame_bits(ws[i], 8, 0, 1);
        end
        fork
            capture(3, 10, "a_b2b");
            begin
                for (int i = 0; i < 3; i++) wr(0, ws[i]);
            end
        join
        repeat (20) @(negedge clk);

        // 7E2 loopback: 0x35 then random words
        mon_sel = 1;
        ws[0] = 9'h035;
        for (int i = 1; i < 5; i++) ws[i] = 9'($urandom_range(0, 127));
        for (int i = 0; i < 5; i++) exp_fr[i] = frame_bits(ws[i], 7, 1, 2);
        fork
            capture(5, 11, "b_7e2_frame");
            begin
                for (int i = 0; i < 5; i++) wr(1, ws[i]);
            end
        join
        for (int i = 0; i < 5; i++) rd(1, "b_rx_word", ws[i]);
        check("b_empty", 32'(b_dov), 0);
        check("b_err_cnt", 32'(b_pe_n + b_fe_n + b_ov_n), 0);

        // 8O1 parity error, then a good random word
        base = c_pe_n;
        bits = frame_bits(9'h000, 8, 2, 1);
        bits[9] = 1'b0;
        inject(2, bits, 11);
        repeat (20) @(negedge clk);
        check("c_perr_once", 32'(c_pe_n - base), 1);
        check("c_no_word", 32'(c_dov), 0);
        w = 9'($urandom_range(0, 255));
        inject(2, frame_bits(w, 8, 2, 1), 11);
        rd(2, "c_good_word", w);
        check("c_err_after_good", 32'(c_pe_n - base + c_fe_n + c_ov_n), 1);

        // 8N1 framing error followed by a clean 0x3C
        base = a_fe_n;
        bits = frame_bits(9'h055, 8, 0, 1);
        bits[9] = 1'b0;
        inject(0, bits, 10);
        repeat (20) @(negedge clk);
        check("a_ferr_once", 32'(a_fe_n - base), 1);
        check("a_ferr_no_word", 32'(a_dov), 0);
        inject(0, frame_bits(9'h03C, 8, 0, 1), 10);
        rd(0, "a_3c_word", 9'h03C);

        // 3-cycle glitch on idle line
        a_inj = 1'b0;
        repeat (3) @(negedge clk);
        a_inj = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_word", 32'(a_dov), 0);
        check("glitch_err_cnt", 32'(a_fe_n - base + a_pe_n + a_ov_n), 1);

        // Depth-4 loopback with no reads: fifth word overruns
        a_loop = 1'b1;
        base   = a_ov_n;
        n_ovr  = 0;
        rxq.delete();
        for (int i = 0; i < 5; i++) begin
            ws[i] = 9'($urandom_range(0, 255));
            if (rxq.size() < 4) rxq.push_back(ws[i]);
            else                n_ovr++;
        end
        for (int i = 0; i < 5; i++) wr(0, ws[i]);
        repeat (700) @(negedge clk);
        check("a_overrun_cnt", 32'(a_ov_n - base), 32'(n_ovr));
        while (rxq.size() > 0) rd(0, "a_fifo_order", rxq.pop_front());
        check("a_fifo_drained", 32'(a_dov), 0);

        // Reset pulsed mid-frame
        w = 9'($urandom_range(0, 255));
        wr(0, w);
        repeat (35) @(negedge clk);
        base = a_pe_n + a_fe_n + a_ov_n;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_sout", 32'(a_sout), 1);
        check("midrst_rdy_dov", 32'({a_rdy, a_dov}), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_rdy_rise", 32'(a_rdy), 1);
        repeat (150) @(negedge clk);
        check("midrst_no_pulse", 32'(a_pe_n + a_fe_n + a_ov_n - base), 0);
        check("midrst_no_word", 32'(a_dov), 0);
        w = 9'($urandom_range(0, 255));
        wr(0, w);
        rd(0, "post_rst_word", w);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
